pc_sequencer: RTL and testbench

//  Program-counter stage of the single-cycle CPU. Holds PC, produces PC+4 and
//  the branch target through two Adder instances, and selects the next PC

---
 rtl/pc_pkg.sv | 20 ++
 rtl/adder.sv | 12 +
 rtl/pc_sequencer.sv | 104 ++++++++++
 tb/tb_pc_sequencer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared encodings for the program-counter stage
package pc_pkg;

  typedef enum logic [1:0] {
    PC_SEQ = 2'b00,
    PC_BR  = 2'b01,
    PC_J   = 2'b10,
    PC_JR  = 2'b11
  } pc_src_e;

  typedef enum logic [1:0] {
    S_BOOT  = 2'b00,
    S_RUN   = 2'b01,
    S_HALT  = 2'b10,
    S_FAULT = 2'b11
  } pc_state_e;

  localparam logic [31:0] ALIGN_MASK = 32'h0000_0003;

endpackage

// File: rtl/adder.sv
// rtl/adder.sv - plain modulo-2^W adder used for PC arithmetic
module adder #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - PC register, next-PC select, boot/run/halt/fault FSM, retire counter
module pc_sequencer
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          CNT_W        = 32
) (
  input  logic             CLK,
  input  logic             Reset_n,
  input  logic             Stall,
  input  logic             imem_ready,
  input  logic [1:0]       PCSrc,
  input  logic             Branch_Taken,
  input  logic [31:0]      Imm32,
  input  logic [25:0]      JumpIdx,
  input  logic [31:0]      RegTarget,
  input  logic             Halt,
  output logic [31:0]      PC,
  output logic [31:0]      PC_plus4,
  output logic             fetch_valid,
  output logic             halted,
  output logic             misalign_err,
  output logic [CNT_W-1:0] inst_count
);

  pc_state_e        state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      pc_plus4;
  logic [31:0]      br_target;
  logic [31:0]      next_pc;
  logic             advance;
  logic             jr_misaligned;

  adder #(.W(32)) u_inc (
    .a   (pc_q),
    .b   (32'd4),
    .sum (pc_plus4)
  );

  adder #(.W(32)) u_br (
    .a   (pc_plus4),
    .b   (Imm32 << 2),
    .sum (br_target)
  );

  assign advance       = (state_q == S_RUN) && imem_ready && !Stall;
  assign jr_misaligned = (PCSrc == PC_JR) && ((RegTarget & ALIGN_MASK) != 32'd0);

  always_comb begin
    next_pc = pc_plus4;
    case (PCSrc)
      PC_SEQ:  next_pc = pc_plus4;
      PC_BR:   next_pc = Branch_Taken ? br_target : pc_plus4;
      PC_J:    next_pc = {pc_plus4[31:28], JumpIdx, 2'b00};
      PC_JR:   next_pc = RegTarget;
      default: next_pc = pc_plus4;
    endcase
  end

  // A halt or faulting jr freezes PC at the offending instruction for debug.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_BOOT: state_d = S_RUN;
      S_RUN: begin
        if (advance) begin
          if (Halt) begin
            state_d = S_HALT;
            cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end else if (jr_misaligned) begin
            state_d = S_FAULT;
          end else begin
            pc_d  = next_pc;
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_VECTOR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign PC           = pc_q;
  assign PC_plus4     = pc_plus4;
  assign fetch_valid  = (state_q == S_RUN);
  assign halted       = (state_q == S_HALT);
  assign misalign_err = (state_q == S_FAULT);
  assign inst_count   = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed-vector bench for pc_sequencer
module tb_pc_sequencer;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        imem_ready;
  logic [1:0]  pc_src;
  logic        br_taken;
  logic [31:0] imm32;
  logic [25:0] jump_idx;
  logic [31:0] reg_target;
  logic        halt;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_valid;
  logic        halted;
  logic        misalign_err;
  logic [31:0] inst_count;

  int n_vec;
  int n_err;

  pc_sequencer #(.RESET_VECTOR(32'h0000_0000), .CNT_W(32)) dut (
    .CLK          (clk),
    .Reset_n      (rst_n),
    .Stall        (stall),
    .imem_ready   (imem_ready),
    .PCSrc        (pc_src),
    .Branch_Taken (br_taken),
    .Imm32        (imm32),
    .JumpIdx      (jump_idx),
    .RegTarget    (reg_target),
    .Halt         (halt),
    .PC           (pc),
    .PC_plus4     (pc_plus4),
    .fetch_valid  (fetch_valid),
    .halted       (halted),
    .misalign_err (misalign_err),
    .inst_count   (inst_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] src, input logic [31:0] tgt);
    pc_src     = src;
    reg_target = tgt;
    step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    stall      = 1'b0;
    imem_ready = 1'b1;
    pc_src     = 2'b00;
    br_taken   = 1'b0;
    imm32      = 32'd0;
    jump_idx   = 26'd0;
    reg_target = 32'd0;
    halt       = 1'b0;

    // Reset state, then BOOT for one cycle, then sequential fetch
    do_reset();
    check("rst_pc", pc, 32'h0);
    check("rst_pc4", pc_plus4, 32'h4);
    check("rst_fv", {31'd0, fetch_valid}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_mis", {31'd0, misalign_err}, 32'd0);
    check("rst_cnt", inst_count, 32'd0);
    step();
    check("boot_pc", pc, 32'h0);
    check("boot_fv", {31'd0, fetch_valid}, 32'd1);
    check("boot_cnt", inst_count, 32'd0);
    for (int i = 1; i <= 4; i++) begin
      step();
      check("seq_pc", pc, 32'(4 * i));
    end
    check("seq_cnt", inst_count, 32'd4);

    // Branch taken / not taken from 0x100 with offset -2 words
    issue(2'b11, 32'h0000_0100);
    check("jr_pc", pc, 32'h100);
    pc_src   = 2'b01;
    imm32    = 32'hFFFF_FFFE;
    br_taken = 1'b1;
    step();
    check("br_taken", pc, 32'h0FC);
    issue(2'b11, 32'h0000_0100);
    pc_src   = 2'b01;
    br_taken = 1'b0;
    step();
    check("br_not", pc, 32'h104);
    check("br_cnt", inst_count, 32'd8);

    // Jump keeps upper nibble of PC+4
    issue(2'b11, 32'h4000_0010);
    pc_src   = 2'b10;
    jump_idx = 26'h000_0040;
    step();
    check("jump_pc", pc, 32'h4000_0100);

    // Wrap at top of address space
    issue(2'b11, 32'hFFFF_FFFC);
    check("wrap_pc4", pc_plus4, 32'h0);
    issue(2'b00, 32'h0);
    check("wrap_pc", pc, 32'h0);
    check("wrap_cnt", inst_count, 32'd12);

    // Stall and imem_ready=0 both hold
    stall = 1'b1;
    issue(2'b00, 32'h0);
    check("stall_pc", pc, 32'h0);
    stall      = 1'b0;
    imem_ready = 1'b0;
    issue(2'b00, 32'h0);
    check("nordy_pc", pc, 32'h0);
    check("hold_cnt", inst_count, 32'd12);
    imem_ready = 1'b1;

    // Misaligned jr faults, PC and counter frozen, sticky until reset
    issue(2'b00, 32'h0);
    check("pre_fault_pc", pc, 32'h4);
    issue(2'b11, 32'h0000_0202);
    check("fault_mis", {31'd0, misalign_err}, 32'd1);
    check("fault_fv", {31'd0, fetch_valid}, 32'd0);
    check("fault_pc", pc, 32'h4);
    check("fault_cnt", inst_count, 32'd13);
    issue(2'b00, 32'h0);
    check("fault_sticky", {31'd0, misalign_err}, 32'd1);
    check("fault_pc2", pc, 32'h4);

    // Halt held off by stall, taken on release
    do_reset();
    check("rst2_mis", {31'd0, misalign_err}, 32'd0);
    step();
    issue(2'b00, 32'h0);
    issue(2'b00, 32'h0);
    check("pre_halt_pc", pc, 32'h8);
    halt  = 1'b1;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stalled_halt_pc", pc, 32'h8);
      check("stalled_halt_h", {31'd0, halted}, 32'd0);
      check("stalled_halt_cnt", inst_count, 32'd2);
    end
    stall = 1'b0;
    step();
    check("halt_h", {31'd0, halted}, 32'd1);
    check("halt_pc", pc, 32'h8);
    check("halt_cnt", inst_count, 32'd3);
    check("halt_fv", {31'd0, fetch_valid}, 32'd0);
    step();
    check("halt_stay_pc", pc, 32'h8);
    check("halt_stay_cnt", inst_count, 32'd3);
    halt = 1'b0;

    // Asynchronous reset mid-cycle
    #2;
    rst_n = 1'b0;
    #1;
    check("async_pc", pc, 32'h0);
    check("async_h", {31'd0, halted}, 32'd0);
    check("async_cnt", inst_count, 32'd0);
    check("async_fv", {31'd0, fetch_valid}, 32'd0);
    step();
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
